// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a synchronous FIFO read port, one word per frame.
// Frames are LSB-first with start bit, optional parity and 1 or 2 stop bits, sent back-to-back.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  rd_en_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  rd_valid_i,
  input  logic                  tx_enable_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic [15:0]           frame_count_o
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_WIDTH + STOP_BITS);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_WIDTH - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);
  localparam logic             OddPar   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                  state_q, state_d;
  logic [BaudW-1:0]        baud_q, baud_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic [15:0]             frame_count_q, frame_count_d;
  logic                    bit_end, frame_end, pop;

  assign bit_end   = (baud_q == BaudLast);
  assign frame_end = (state_q == StStop) && bit_end && (bit_q == StopLast);
  // Gated by rst_ni so the idle state seen during reset can never request a pop.
  assign pop       = rst_ni && tx_enable_i && rd_valid_i && ((state_q == StIdle) || frame_end);
  assign rd_en_o   = pop;

  always_comb begin
    state_d       = state_q;
    baud_d        = baud_q;
    bit_d         = bit_q;
    shreg_d       = shreg_q;
    par_d         = par_q;
    frame_count_d = frame_count_q;
    if (state_q != StIdle) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      StIdle: ;
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == DataLast) begin
            state_d = (PARITY_EN != 0) ? StParity : StStop;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          bit_d   = '0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_q == StopLast) begin
            frame_count_d = frame_count_q + 16'd1;
            state_d       = StIdle;
            bit_d         = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A pop overrides the end-of-frame return to idle, giving a gapless next start bit.
    if (pop) begin
      state_d = StStart;
      baud_d  = '0;
      bit_d   = '0;
      shreg_d = rd_data_i;
      par_d   = (^rd_data_i) ^ OddPar;
    end
  end

  always_comb begin
    busy_d = (state_d != StIdle);
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shreg_d[0];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      baud_q        <= '0;
      bit_q         <= '0;
      shreg_q       <= '0;
      par_q         <= 1'b0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      shreg_q       <= shreg_d;
      par_q         <= par_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign tx_o          = tx_q;
  assign busy_o        = busy_q;
  assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: an 8N1 instance and an 8O2 instance, each fed by a small FIFO model.
module tb_fifo_uart_tx;

  int checks   = 0;
  int failures = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Instance A: 8N1, 4 clocks per bit.
  logic       rd_en_a, rd_valid_a, tx_en_a, tx_a, busy_a;
  logic [7:0] rd_data_a;
  logic [15:0] fc_a;
  logic [7:0] mem_a [16];
  logic [3:0] wp_a = '0;
  logic [3:0] rp_a = '0;
  assign rd_valid_a = (wp_a != rp_a);
  assign rd_data_a  = mem_a[rp_a];
  always @(posedge clk) if (rd_en_a) rp_a <= rp_a + 4'd1;

  // Instance B: 8 data, odd parity, 2 stop bits, 4 clocks per bit.
  logic       rd_en_b, rd_valid_b, tx_en_b, tx_b, busy_b;
  logic [7:0] rd_data_b;
  logic [15:0] fc_b;
  logic [7:0] mem_b [16];
  logic [3:0] wp_b = '0;
  logic [3:0] rp_b = '0;
  assign rd_valid_b = (wp_b != rp_b);
  assign rd_data_b  = mem_b[rp_b];
  always @(posedge clk) if (rd_en_b) rp_b <= rp_b + 4'd1;

  fifo_uart_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rd_en_o(rd_en_a), .rd_data_i(rd_data_a),
    .rd_valid_i(rd_valid_a), .tx_enable_i(tx_en_a), .tx_o(tx_a), .busy_o(busy_a),
    .frame_count_o(fc_a)
  );

  fifo_uart_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rd_en_o(rd_en_b), .rd_data_i(rd_data_b),
    .rd_valid_i(rd_valid_b), .tx_enable_i(tx_en_b), .tx_o(tx_b), .busy_o(busy_b),
    .frame_count_o(fc_b)
  );

  task automatic push_a(input logic [7:0] w);
    mem_a[wp_a] = w;
    wp_a = wp_a + 4'd1;
  endtask

  task automatic push_b(input logic [7:0] w);
    mem_b[wp_b] = w;
    wp_b = wp_b + 4'd1;
  endtask

  // Expected line level of an 8N1 frame at cycle offset pos (4 clocks per bit).
  function automatic logic bit_8n1(input logic [7:0] w, input int pos);
    logic [9:0] f;
    f = {1'b1, w, 1'b0};
    return f[pos / 4];
  endfunction

  task automatic test_reset();
    tx_en_a = 1'b1;
    tx_en_b = 1'b0;
    rst_n   = 1'b0;
    push_a(8'hA5);
    #1;
    checks++; if (rd_en_a !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b want=0", rd_en_a); end
    checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b want=1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    checks++; if (fc_a !== 16'h0) begin failures++; $display("FAIL reset_fc got=%h want=0000", fc_a); end
    checks++; if (tx_b !== 1'b1) begin failures++; $display("FAIL reset_tx_b got=%b want=1", tx_b); end
  endtask

  task automatic test_gating_idle();
    tx_en_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++; if (rd_en_a !== 1'b0) begin failures++; $display("FAIL gate_idle_rd_en cyc=%0d got=%b want=0", i, rd_en_a); end
      checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL gate_idle_tx cyc=%0d got=%b want=1", i, tx_a); end
    end
  endtask

  task automatic test_single_frame();
    tx_en_a = 1'b1;
    #1;
    checks++; if (rd_en_a !== 1'b1) begin failures++; $display("FAIL single_pop got=%b want=1", rd_en_a); end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      checks++; if (tx_a !== bit_8n1(8'hA5, i - 1)) begin failures++; $display("FAIL single_tx cyc=%0d got=%b want=%b", i, tx_a, bit_8n1(8'hA5, i - 1)); end
      checks++; if (rd_en_a !== 1'b0) begin failures++; $display("FAIL single_extra_pop cyc=%0d got=%b want=0", i, rd_en_a); end
      checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL single_busy cyc=%0d got=%b want=1", i, busy_a); end
    end
    @(negedge clk);
    checks++; if (fc_a !== 16'd1) begin failures++; $display("FAIL single_fc got=%0d want=1", fc_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b want=0", busy_a); end
    checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL single_tx_idle got=%b want=1", tx_a); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w3 [3];
    logic       exp_rd;
    w3[0] = 8'h00; w3[1] = 8'hFF; w3[2] = 8'h3C;
    push_a(w3[0]); push_a(w3[1]); push_a(w3[2]);
    #1;
    checks++; if (rd_en_a !== 1'b1) begin failures++; $display("FAIL b2b_pop0 got=%b want=1", rd_en_a); end
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      exp_rd = (i == 40) || (i == 80);
      checks++; if (tx_a !== bit_8n1(w3[(i - 1) / 40], (i - 1) % 40)) begin failures++; $display("FAIL b2b_tx cyc=%0d got=%b want=%b", i, tx_a, bit_8n1(w3[(i - 1) / 40], (i - 1) % 40)); end
      checks++; if (rd_en_a !== exp_rd) begin failures++; $display("FAIL b2b_rd_en cyc=%0d got=%b want=%b", i, rd_en_a, exp_rd); end
    end
    @(negedge clk);
    checks++; if (fc_a !== 16'd4) begin failures++; $display("FAIL b2b_fc got=%0d want=4", fc_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b want=0", busy_a); end
  endtask

  task automatic test_gating_mid();
    push_a(8'h55);
    push_a(8'h66);
    #1;
    checks++; if (rd_en_a !== 1'b1) begin failures++; $display("FAIL gmid_pop got=%b want=1", rd_en_a); end
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i <= 40) begin
        checks++; if (tx_a !== bit_8n1(8'h55, i - 1)) begin failures++; $display("FAIL gmid_tx cyc=%0d got=%b want=%b", i, tx_a, bit_8n1(8'h55, i - 1)); end
      end else begin
        checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL gmid_idle_tx cyc=%0d got=%b want=1", i, tx_a); end
      end
      checks++; if (rd_en_a !== 1'b0) begin failures++; $display("FAIL gmid_rd_en cyc=%0d got=%b want=0", i, rd_en_a); end
      if (i == 10) tx_en_a = 1'b0;
    end
    checks++; if (fc_a !== 16'd5) begin failures++; $display("FAIL gmid_fc got=%0d want=5", fc_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL gmid_busy got=%b want=0", busy_a); end
  endtask

  task automatic test_reset_mid();
    tx_en_a = 1'b1;
    #1;
    checks++; if (rd_en_a !== 1'b1) begin failures++; $display("FAIL rmid_pop got=%b want=1", rd_en_a); end
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      checks++; if (tx_a !== bit_8n1(8'h66, i - 1)) begin failures++; $display("FAIL rmid_tx cyc=%0d got=%b want=%b", i, tx_a, bit_8n1(8'h66, i - 1)); end
    end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_a !== 1'b1) begin failures++; $display("FAIL rmid_tx_rst got=%b want=1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rmid_busy_rst got=%b want=0", busy_a); end
    checks++; if (fc_a !== 16'd0) begin failures++; $display("FAIL rmid_fc_rst got=%0d want=0", fc_a); end
    push_a(8'h81);
    #1;
    checks++; if (rd_en_a !== 1'b0) begin failures++; $display("FAIL rmid_rd_en_rst got=%b want=0", rd_en_a); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (rd_en_a !== 1'b1) begin failures++; $display("FAIL rmid_repop got=%b want=1", rd_en_a); end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      checks++; if (tx_a !== bit_8n1(8'h81, i - 1)) begin failures++; $display("FAIL rmid_frame_tx cyc=%0d got=%b want=%b", i, tx_a, bit_8n1(8'h81, i - 1)); end
      checks++; if (rd_en_a !== 1'b0) begin failures++; $display("FAIL rmid_frame_rd_en cyc=%0d got=%b want=0", i, rd_en_a); end
    end
    @(negedge clk);
    checks++; if (fc_a !== 16'd1) begin failures++; $display("FAIL rmid_fc got=%0d want=1", fc_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rmid_busy_end got=%b want=0", busy_a); end
  endtask

  task automatic test_wrap();
    force dut_a.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut_a.frame_count_q;
    push_a(8'h12);
    for (int i = 1; i <= 40; i++) @(negedge clk);
    checks++; if (fc_a !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got=%h want=ffff", fc_a); end
    @(negedge clk);
    checks++; if (fc_a !== 16'h0000) begin failures++; $display("FAIL wrap_post got=%h want=0000", fc_a); end
  endtask

  task automatic test_parity_odd();
    // 0x07 framed LSB-first: start 0, data 1110_0000, odd parity 0, stop 1 1.
    logic [11:0] v;
    v = 12'b1100_0000_1110;
    tx_en_b = 1'b1;
    push_b(8'h07);
    #1;
    checks++; if (rd_en_b !== 1'b1) begin failures++; $display("FAIL par_pop got=%b want=1", rd_en_b); end
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      checks++; if (tx_b !== v[(i - 1) / 4]) begin failures++; $display("FAIL par_tx cyc=%0d got=%b want=%b", i, tx_b, v[(i - 1) / 4]); end
      checks++; if (busy_b !== 1'b1) begin failures++; $display("FAIL par_busy cyc=%0d got=%b want=1", i, busy_b); end
    end
    @(negedge clk);
    checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL par_busy_end got=%b want=0", busy_b); end
    checks++; if (fc_b !== 16'd1) begin failures++; $display("FAIL par_fc got=%0d want=1", fc_b); end
    checks++; if (tx_b !== 1'b1) begin failures++; $display("FAIL par_tx_idle got=%b want=1", tx_b); end
  endtask

  initial begin
    tx_en_a = 1'b0;
    tx_en_b = 1'b0;
    test_reset();
    test_gating_idle();
    test_single_frame();
    test_back_to_back();
    test_gating_mid();
    test_reset_mid();
    test_wrap();
    test_parity_odd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
